// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// funct3 codes, and the request legality check applied at accept time.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal encodings and misaligned half/word accesses both count as errors.
    function automatic logic req_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (we) begin
            if (funct3 > F3_W) bad = 1'b1;
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: bad = 1'b0;
                default:                        bad = 1'b1;
            endcase
        end
        case (funct3)
            F3_H, F3_HU: if (addr_lo[0])      bad = 1'b1;
            F3_W:        if (addr_lo != 2'b0) bad = 1'b1;
            default:     ;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: merges store data into an old word and extracts /
// extends load data from a fetched word. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    input  logic [31:0] rd_word,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged = old_word;
        case (funct3)
            F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Little-endian lanes: byte lane is addr[1:0], half lane is addr[1].
    always_comb begin
        byte_sel  = rd_word[{lane, 3'b000} +: 8];
        half_sel  = rd_word[{lane[1], 4'b0000} +: 16];
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-wide data memory; sub-word stores are done as
// read-modify-write, loads are registered and extended before the response.
module lsu_rmw #(
    parameter int DRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               dram_we,
    output logic [DRAM_AW-1:0] dram_a,
    output logic [31:0]        dram_d,
    input  logic [31:0]        dram_rd
);

    import lsu_pkg::*;

    lsu_state_t        state;
    lsu_state_t        state_next;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [DRAM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              illegal;
    logic [31:0]       merged;
    logic [31:0]       load_data;

    // Upper address bits alias onto the memory and are deliberately dropped.
    logic              addr_hi_unused;
    assign addr_hi_unused = ^req_addr[31:DRAM_AW+2];

    assign illegal = req_illegal(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3    (funct3_q),
        .lane      (addr_q[1:0]),
        .wdata     (wdata_q),
        .old_word  (old_q),
        .rd_word   (dram_rd),
        .merged    (merged),
        .load_data (load_data)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        dram_we    = 1'b0;
        dram_d     = 32'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal)
                        state_next = RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                state_next = we_q ? WRITE : RESP;
            end
            WRITE: begin
                dram_we    = 1'b1;
                dram_d     = merged;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response registers only change on the edge entering RESP, so they hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            old_q    <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[DRAM_AW+1:0];
                wdata_q  <= req_wdata;
                if (illegal) begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b1;
                end
            end
            if (state == READ) begin
                if (we_q) begin
                    old_q <= dram_rd;
                end else begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                end
            end
            if (state == WRITE) begin
                rdata_q <= 32'b0;
                err_q   <= 1'b0;
            end
        end
    end

    assign dram_a    = addr_q[DRAM_AW+1:2];
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 Parameter: DRAM_AW, default 14, dram_a word-address width; byte-address bits [DRAM_AW+1:2] select the word.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  core presents a load/store request.
REQ-005 Port: req_ready  output  1  block accepts a request; transfer occurs when req_valid && req_ready at a rising edge.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  input  3  RISC-V funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-008 Port: req_addr  input  32  byte address (ALU result).
REQ-009 Port: req_wdata  input  32  store data (rs2).
REQ-010 Port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  output  32  extended load result, valid with rsp_valid.
REQ-012 Port: rsp_err  output  1  misaligned or illegal request, valid with rsp_valid.
REQ-013 Port: dram_we  output  1  word write enable to data memory.
REQ-014 Port: dram_a  output  DRAM_AW  word address to data memory.
REQ-015 Port: dram_d  output  32  write data to data memory.
REQ-016 Port: dram_rd  input  32  asynchronous (same-cycle) read data from data memory.

Function
REQ-017 FSM states: IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 On accept, the block latches req_we, req_funct3, req_addr and req_wdata; later changes on req_* have no effect until the next accept.
REQ-019 Error check at accept:
- LH/LHU/SH with addr[0] != 0 is an error.
- LW/SW with addr[1:0] != 0 is an error.
- Loads with funct3 011/110/111 and stores with funct3 > 010 are errors.
- Any error goes IDLE->RESP with rsp_err=1 and no memory access.
REQ-020 Load path: IDLE->READ->RESP.
- READ drives dram_a and registers dram_rd.
- rsp_valid asserts 2 cycles after accept.
REQ-021 SW path: IDLE->WRITE->RESP; dram_d = wdata.
REQ-022 SB/SH path: IDLE->READ->WRITE->RESP.
- READ captures the old word.
- WRITE drives the merged word: selected byte/half lanes replaced by wdata[7:0]/[15:0]; other lanes unchanged.
REQ-023 dram_we = 1 only in WRITE, for exactly one cycle per store; never asserted for loads or errors.
REQ-024 Byte lanes are little-endian; lane index = addr[1:0] (byte) or addr[1] (half).
REQ-025 Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
REQ-026 Address bits above DRAM_AW+1 are ignored, so addresses alias (wrap) modulo 2^(DRAM_AW+2) bytes.
REQ-027 RESP lasts one cycle, then returns to IDLE.
- rsp_rdata and rsp_err hold their values until the next RESP.
- Store responses give rsp_rdata = 0 and rsp_err = 0.
REQ-028 A request presented during RESP is not accepted; it is accepted in the following IDLE cycle. Minimum issue interval: 3 cycles for loads/SW, 4 cycles for SB/SH.
REQ-029 dram_a = latched address word index in all non-IDLE states; dram_d = 0 outside WRITE.

Reset
REQ-030 rst_n low asynchronously forces:
- state = IDLE, so req_ready = 1.
- dram_we = 0, rsp_valid = 0, rsp_err = 0.
- rsp_rdata = 0, dram_a = 0, dram_d = 0, all latched request fields = 0.
REQ-031 Reset during READ or WRITE aborts the operation without producing a response; if rst_n asserts before the WRITE-cycle edge, no memory write occurs.

Structure
REQ-032 Shared package lsu_pkg holds the state encoding and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-033 One combinational sub-module, lsu_align, performs store-lane merge and load-lane extract/extend; the FSM and registers stay in lsu_rmw.

Verification
REQ-034 Word 0x0 = 0x11223344; LB addr 0x3 -> rsp_rdata 0x00000011 two cycles after accept; LB addr 0x1 with word 0x0 = 0x1122F344 -> 0xFFFFFFF3.
REQ-035 Word 0x4 = 0xAABBCCDD; SB addr 0x6, wdata 0x000000EE -> one dram_we pulse with dram_d 0xAAEECCDD; rsp_valid 3 cycles after accept.
REQ-036 LHU addr 0x2 on word 0x8000_1234 -> 0x00008000; LH at the same address -> 0xFFFF8000.
REQ-037 SW addr 0x2 -> rsp_err = 1 one cycle after accept, no dram_we; load funct3 011 -> rsp_err = 1.
REQ-038 Back-to-back requests with req_valid held high -> req_ready low outside IDLE, every request answered exactly once and in order.
REQ-039 rst_n pulsed low during WRITE of an SH -> dram_we drops immediately, no rsp_valid, and the memory word stays unchanged.
